// File: rtl/uart_rx_ctrl.sv
// Oversampling 8N1 UART receiver: start detect, mid-bit sampling, LSB-first
// deserialisation, valid/ready output register, framing and overrun pulses.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [1:0]             r_sync;
  logic [CW-1:0]          r_cnt;
  logic [BW-1:0]          r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;
  logic                   w_rx_s;
  logic                   w_half_hit;
  logic                   w_bit_hit;
  logic                   w_sample_data;
  logic                   w_good;
  logic                   w_bad;

  assign w_rx_s     = r_sync[1];
  assign w_half_hit = (r_cnt == CW'(H - 1));
  assign w_bit_hit  = (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_next  = r_state;
    w_sample_data = 1'b0;
    w_good        = 1'b0;
    w_bad         = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_rx_s) w_state_next = S_START;
      S_START: if (w_half_hit) w_state_next = w_rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_bit_hit) begin
          w_sample_data = 1'b1;
          if (r_bit_idx == BW'(DATA_BITS - 1)) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_hit) begin
          if (w_rx_s) begin
            w_good       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_bad        = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: if (w_rx_s) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sync  <= 2'b11;
    end else begin
      r_state <= w_state_next;
      r_sync  <= {r_sync[0], rx};
    end
  end

  // The cycle counter restarts on every state change and every data-bit
  // sample, so each sample point is simply a fixed count from the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if ((w_state_next != r_state) || w_sample_data) r_cnt <= '0;
      else                                            r_cnt <= r_cnt + CW'(1);
      if (r_state != S_DATA)  r_bit_idx <= '0;
      else if (w_sample_data) r_bit_idx <= r_bit_idx + BW'(1);
      if (w_sample_data) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
    end
  end

  // A completed frame loads when the buffer is empty or being drained this
  // same cycle; otherwise it is dropped and the old byte is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      r_overrun   <= w_good && r_valid && !rx_ready;
      if (w_good && (!r_valid || rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit; each task drives one
// scenario and checks its own results.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  int cyc = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int vcyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] rise_data = 8'h00;
  logic prev_valid = 1'b0;

  uart_rx_ctrl #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rise_cnt  = rise_cnt + 1;
      rise_cyc  = cyc;
      rise_data = rx_data;
    end
    if (rx_valid) vcyc = vcyc + 1;
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (overrun) ovr_cnt = ovr_cnt + 1;
    prev_valid = rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 160-cycle frame. start_cyc is the tb cycle count of the edge
  // where the start bit went low. If pulse_at >= 0, rx_ready is 1 only during
  // frame cycle pulse_at.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int pulse_at, output int start_cyc);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    @(posedge clk);
    #1;
    start_cyc = cyc;
    for (int i = 0; i < 160; i++) begin
      rx = bits[i/16];
      if (pulse_at >= 0) rx_ready = (i == pulse_at);
      @(posedge clk);
      #1;
    end
    if (pulse_at >= 0) rx_ready = 1'b0;
    rx = 1'b1;
  endtask

  task automatic test_reset;
    tests_run++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b ferr=%b ovr=%b busy=%b data=%h, required all 0",
               rx_valid, frame_err, overrun, busy, rx_data);
    end
    $display("[TB] reset: valid=%b busy=%b data=%h", rx_valid, busy, rx_data);
  endtask

  task automatic test_basic;
    int s, r0, v0, f0, o0;
    rx_ready = 1'b1;
    r0 = rise_cnt; v0 = vcyc; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, -1, s);
    tick(10);
    // start edge + 2 sync cycles gives T0; valid is visible at T0+153
    tests_run++;
    if (rise_cnt - r0 !== 1 || rise_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL basic_data: rises=%0d data=%h, required 1 / a5", rise_cnt - r0, rise_data);
    end
    tests_run++;
    if (rise_cyc !== s + 155) begin
      tests_failed++;
      $display("FAIL basic_latency: valid at +%0d, required +155", rise_cyc - s);
    end
    tests_run++;
    if (vcyc - v0 !== 1) begin
      tests_failed++;
      $display("FAIL basic_valid_width: %0d cycles, required 1", vcyc - v0);
    end
    tests_run++;
    if (ferr_cnt !== f0 || ovr_cnt !== o0) begin
      tests_failed++;
      $display("FAIL basic_flags: ferr=%0d ovr=%0d, required 0 / 0", ferr_cnt - f0, ovr_cnt - o0);
    end
    $display("[TB] basic: sent a5 got %h latency +%0d", rise_data, rise_cyc - s);
  endtask

  task automatic test_glitch;
    int s, r0, f0;
    logic b_before, b_after;
    r0 = rise_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(6);
    b_before = busy;
    tick(1);
    b_after = busy;
    tests_run++;
    if (b_before !== 1'b1 || b_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch_idle_return: busy %b then %b, required 1 then 0", b_before, b_after);
    end
    tick(20);
    tests_run++;
    if (rise_cnt !== r0 || ferr_cnt !== f0) begin
      tests_failed++;
      $display("FAIL glitch_no_output: rises=%0d ferr=%0d, required 0 / 0", rise_cnt - r0, ferr_cnt - f0);
    end
    send_frame(8'h3C, 1'b1, -1, s);
    tick(10);
    tests_run++;
    if (rise_cnt - r0 !== 1 || rise_data !== 8'h3C) begin
      tests_failed++;
      $display("FAIL glitch_next_frame: rises=%0d data=%h, required 1 / 3c", rise_cnt - r0, rise_data);
    end
    $display("[TB] glitch: then sent 3c got %h", rise_data);
  endtask

  task automatic test_frame_err;
    int s, r0, f0, o0;
    r0 = rise_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h55, 1'b0, -1, s);
    rx = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || ferr_cnt - f0 !== 1 || rise_cnt !== r0 || ovr_cnt !== o0) begin
      tests_failed++;
      $display("FAIL ferr_pulse: busy=%b ferr=%0d rises=%0d ovr=%0d, required 1/1/0/0",
               busy, ferr_cnt - f0, rise_cnt - r0, ovr_cnt - o0);
    end
    tick(30);
    tests_run++;
    if (busy !== 1'b1 || rise_cnt !== r0) begin
      tests_failed++;
      $display("FAIL ferr_break_hold: busy=%b rises=%0d, required 1 / 0", busy, rise_cnt - r0);
    end
    rx = 1'b1;
    tick(4);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ferr_break_exit: busy=%b, required 0", busy);
    end
    send_frame(8'h12, 1'b1, -1, s);
    tick(10);
    tests_run++;
    if (rise_cnt - r0 !== 1 || rise_data !== 8'h12 || ferr_cnt - f0 !== 1) begin
      tests_failed++;
      $display("FAIL ferr_next_frame: rises=%0d data=%h ferr=%0d, required 1 / 12 / 1",
               rise_cnt - r0, rise_data, ferr_cnt - f0);
    end
    $display("[TB] frame_err: 55 flagged, then got %h", rise_data);
  endtask

  task automatic test_back_to_back;
    int s, r0, o0, f0;
    rx_ready = 1'b0;
    r0 = rise_cnt; o0 = ovr_cnt; f0 = ferr_cnt;
    send_frame(8'h11, 1'b1, -1, s);
    send_frame(8'h22, 1'b1, -1, s);
    tick(10);
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11 || rise_cnt - r0 !== 1) begin
      tests_failed++;
      $display("FAIL overrun_hold: valid=%b data=%h rises=%0d, required 1 / 11 / 1",
               rx_valid, rx_data, rise_cnt - r0);
    end
    tests_run++;
    if (ovr_cnt - o0 !== 1 || ferr_cnt !== f0) begin
      tests_failed++;
      $display("FAIL overrun_pulse: ovr=%0d ferr=%0d, required 1 / 0", ovr_cnt - o0, ferr_cnt - f0);
    end
    rx_ready = 1'b1;
    tick(1);
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_drain: valid=%b, required 0", rx_valid);
    end
    $display("[TB] back_to_back: held %h, overruns %0d", rx_data, ovr_cnt - o0);
  endtask

  task automatic test_reset_mid;
    int s, r0, f0;
    rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1, -1, s);
    tick(5);
    rx = 1'b0;
    tick(40);
    rx = 1'b1;
    tick(5);
    tests_run++;
    if (busy !== 1'b1 || rx_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_setup: busy=%b valid=%b, required 1 / 1", busy, rx_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: valid=%b ferr=%b ovr=%b busy=%b data=%h, required all 0",
               rx_valid, frame_err, overrun, busy, rx_data);
    end
    tick(3);
    rst_n = 1'b1;
    tick(200);
    r0 = rise_cnt; f0 = ferr_cnt;
    tests_run++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: valid=%b busy=%b, required 0 / 0", rx_valid, busy);
    end
    rx_ready = 1'b1;
    send_frame(8'hC3, 1'b1, -1, s);
    tick(10);
    tests_run++;
    if (rise_cnt - r0 !== 1 || rise_data !== 8'hC3 || ferr_cnt !== f0) begin
      tests_failed++;
      $display("FAIL rstmid_next_frame: rises=%0d data=%h ferr=%0d, required 1 / c3 / 0",
               rise_cnt - r0, rise_data, ferr_cnt - f0);
    end
    $display("[TB] reset_mid: after reset got %h", rise_data);
  endtask

  task automatic test_simultaneous;
    int s, r0, o0;
    rx_ready = 1'b0;
    send_frame(8'h00, 1'b1, -1, s);
    tick(5);
    r0 = rise_cnt; o0 = ovr_cnt;
    // frame cycle 154 is the stop-sample cycle
    send_frame(8'hFF, 1'b1, 154, s);
    tick(5);
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hFF) begin
      tests_failed++;
      $display("FAIL simul_load: valid=%b data=%h, required 1 / ff", rx_valid, rx_data);
    end
    tests_run++;
    if (ovr_cnt !== o0 || rise_cnt !== r0) begin
      tests_failed++;
      $display("FAIL simul_no_overrun: ovr=%0d new_rises=%0d, required 0 / 0",
               ovr_cnt - o0, rise_cnt - r0);
    end
    rx_ready = 1'b1;
    tick(1);
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_drain: valid=%b, required 0", rx_valid);
    end
    $display("[TB] simultaneous: got %h, overruns %0d", rx_data, ovr_cnt - o0);
  endtask

  initial begin
    rst_n = 1'b0;
    tick(3);
    test_reset;
    rst_n = 1'b1;
    tick(5);
    test_basic;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_simultaneous;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
